xdma_c2h_desc_issuer: RTL and testbench
=======================================

# xdma_c2h_desc_issuer

Card-to-host write engine that sits directly upstream of the XDMA C2H channel 0 and feeds both its descriptor-bypass port and its C2H AXI-Stream port. It accepts one write request (host address, byte length) from user logic, issues the matching bypass descriptor, and forwards the payload with XDMA-correct `tkeep`/`tlast`. It also tracks descriptors still in flight using the `c2h_sts[3]` completion pulse and throttles new requests at a fixed outstanding limit.

## Interface
Parameters:
- `DATA_WIDTH`, default 256: stream width in bits; `DATA_WIDTH/8` bytes per beat, always a power of two.
- `ADDR_WIDTH`, default 64: host address width.
- `LEN_WIDTH`, default 28: byte length width; matches the bypass `len` field.
- `MAX_OUTSTANDING`, default 4: maximum number of issued descriptors without a `desc_done`; must be 1..15.

Ports:
- `CLK` input 1: the single clock; all logic is in this domain.
- `RST` input 1: asynchronous, active-high reset.
- `req_valid` input 1; `req_ready` output 1; `req_addr` input ADDR_WIDTH; `req_len` input LEN_WIDTH: request handshake, host destination address, and byte length.
- `s_tvalid` input 1, `s_tready` output 1, `s_tdata` input DATA_WIDTH, `s_tlast` input 1: upstream payload.
- `m_tvalid` output 1, `m_tready` input 1, `m_tdata` output DATA_WIDTH, `m_tkeep` output DATA_WIDTH/8, `m_tlast` output 1: to XDMA `s_axis_c2h_*_0`.
- `dsc_ready` input 1, `dsc_load` output 1, `dsc_src_addr` output 64, `dsc_dst_addr` output ADDR_WIDTH, `dsc_len` output LEN_WIDTH, `dsc_ctl` output 16: to XDMA `c2h_dsc_byp_*_0`.
- `desc_done` input 1: `c2h_sts_0[3]`, a one-cycle pulse per completed descriptor.
- `outstanding` output 4: current in-flight count.
- `busy` output 1: high whenever state ≠ IDLE or `outstanding` ≠ 0.
- `err_len` output 1: sticky length-error flag.

## Operation
- The FSM has four states: IDLE, DESC, DATA, and WAIT.
- **IDLE:**
  - `req_ready` = (`outstanding` < MAX_OUTSTANDING).
  - On accept with `req_len` ≠ 0: latch the address and length, load `beats_left` = ceil(`req_len` / (DATA_WIDTH/8)) using LEN_WIDTH+1 bits, then go to DESC.
  - On accept with `req_len` = 0: drop the request, set `err_len`, stay in IDLE.
- **DESC:**
  - `dsc_load` = `dsc_ready`, combinational, so it is one cycle only.
  - Descriptor fields: `dsc_dst_addr` = latched address; `dsc_len` = latched length; `dsc_src_addr` = 0; `dsc_ctl` = 16'h0010 (EOP).
  - The cycle `dsc_load` is high, go to DATA.
- **DATA:**
  - Pass-through: `m_tvalid` = `s_tvalid`, `s_tready` = `m_tready`, `m_tdata` = `s_tdata`.
  - Each transfer (`m_tvalid` & `m_tready`) decrements `beats_left`.
  - `m_tlast` = (`beats_left` == 1).
  - `m_tkeep` is all ones, except on the last beat: r = len mod (DATA_WIDTH/8); keep = all ones if r = 0, otherwise (1<<r)−1.
  - When the last beat transfers: go to IDLE if `outstanding` < MAX_OUTSTANDING after the update, otherwise go to WAIT.
- **WAIT:** go to IDLE on the first cycle where `outstanding` < MAX_OUTSTANDING.
- **Outstanding counter:**
  - +1 on `dsc_load`; −1 on `desc_done`.
  - Both in the same cycle: unchanged.
  - `desc_done` while the counter is 0: ignored and saturates at 0.
- Outside DATA, `m_tvalid` = 0 and `s_tready` = 0.
- `err_len` clears only on reset.

## Timing
- Reset values:
  - `req_ready` = 0 while `RST` is asserted; it is 1 on the first cycle in IDLE after reset.
  - 0 on reset: `dsc_load`, `m_tvalid`, `m_tlast`, `s_tready`, `outstanding`, `busy`, `err_len`.
  - `dsc_*` data fields = 0 on reset.
  - State = IDLE.
- Request accept at cycle N puts the block in DESC at N+1. `dsc_load` is at N+1 at the earliest, or the first later cycle with `dsc_ready`.
- The first payload beat can transfer in the cycle after `dsc_load`. The data path is zero-latency combinational.
- `dsc_*` fields are registered and stable from DESC entry until the next accept.
- Reset in mid-operation aborts the transfer immediately: no `m_tlast` is issued, `outstanding` is forced to 0, and the partial packet is not retried.
- After the last beat transfers, a new request can be accepted in the cycle after the block returns to IDLE.

## Configuration
- `XDMA_C2H_LEN_CHECK_EN` defined:
  - In DATA, a transfer with `s_tlast` ≠ `m_tlast` sets `err_len` the following cycle.
  - Forwarding continues on the block-computed `m_tlast`; upstream `s_tlast` is never forwarded.
- Not defined:
  - `s_tlast` is ignored.
  - `err_len` is set only by the zero-length drop.

## Test plan
- **Single request, 64 bytes to 0x1000, DATA_WIDTH 256:** one `dsc_load` with len 64 and ctl 0x0010; 2 beats, both keep 0xFFFFFFFF; tlast on beat 2; `outstanding` goes 0→1, then 1→0 on `desc_done`.
- **Unaligned length, 33 bytes:** 2 beats; beat 2 keep = 0x00000001 with tlast.
- **Limit:** 5 back-to-back 32-byte requests with no `desc_done`, MAX_OUTSTANDING 4. `req_ready` stays 0 after the 4th descriptor; one `desc_done` re-enables it and the 5th issues.
- **Simultaneous events:** `dsc_load` and `desc_done` in the same cycle leave `outstanding` unchanged. Backpressure with `m_tready` toggling every cycle loses no beats and keeps `m_tdata` in order.
- **Length check, macro defined:** 64-byte request with upstream `s_tlast` on beat 1. `err_len` rises the next cycle and the packet still ends on beat 2. A zero-length request is dropped with `err_len` set and no `dsc_load`.
- **Reset mid-operation:** `RST` asserted during beat 1 of 4. All outputs go to reset values asynchronously; the next request after release issues normally with `outstanding` counting from 0.

Source files
------------

// File: rtl/xdma_c2h_desc_issuer.sv
// xdma_c2h_desc_issuer: card-to-host write engine feeding the XDMA C2H channel 0
// descriptor-bypass port and C2H AXI-Stream port. One request (address, byte
// length) produces one EOP bypass descriptor followed by the payload, with
// tkeep/tlast computed from the length. In-flight descriptors are counted
// against desc_done pulses and new requests stall at MAX_OUTSTANDING.
//
// Optional build macro: XDMA_C2H_LEN_CHECK_EN -- when defined, an upstream
// s_tlast that disagrees with the computed m_tlast on a transfer sets err_len.
module xdma_c2h_desc_issuer #(
  parameter int DATA_WIDTH      = 256,
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 28,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  // write request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  // upstream payload
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tlast,
  // to XDMA s_axis_c2h_*_0
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  // to XDMA c2h_dsc_byp_*_0
  input  logic                    dsc_ready,
  output logic                    dsc_load,
  output logic [63:0]             dsc_src_addr,
  output logic [ADDR_WIDTH-1:0]   dsc_dst_addr,
  output logic [LEN_WIDTH-1:0]    dsc_len,
  output logic [15:0]             dsc_ctl,
  // completion and status
  input  logic                    desc_done,
  output logic [3:0]              outstanding,
  output logic                    busy,
  output logic                    err_len
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(KEEP_WIDTH);

  typedef logic [LEN_WIDTH:0]  beats_t;
  typedef logic [KEEP_WIDTH-1:0] keep_t;
  typedef logic [3:0]          cnt_t;

  localparam cnt_t  MAX_OUT    = cnt_t'(MAX_OUTSTANDING);
  localparam beats_t BEAT_ROUND = beats_t'(KEEP_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DESC = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [15:0]             ctl_q, ctl_d;
  beats_t                  beats_left_q, beats_left_d;
  cnt_t                    outstanding_q, outstanding_d;
  logic                    err_len_q, err_len_d;

  logic                    room_s;
  logic                    req_ready_s;
  logic                    req_fire_s;
  logic                    dsc_load_s;
  logic                    in_data_s;
  logic                    xfer_s;
  logic                    last_beat_s;
  beats_t                  beats_calc_s;
  logic [BEAT_SHIFT-1:0]   tail_bytes_s;
  keep_t                   keep_tail_s;

  // Anything else must still consume upstream s_tlast in the default build.
  logic                    unused_tlast_s;
  assign unused_tlast_s = s_tlast;

  // A descriptor may be issued only while below the in-flight limit.
  assign room_s       = (outstanding_q < MAX_OUT);
  assign in_data_s    = (state_q == ST_DATA);
  assign xfer_s       = in_data_s & s_tvalid & m_tready;
  assign last_beat_s  = in_data_s & (beats_left_q == beats_t'(1));
  assign req_fire_s   = req_valid & req_ready_s;

  // Beat count rounds the byte length up to whole stream words.
  assign beats_calc_s = ({1'b0, req_len} + BEAT_ROUND) >> BEAT_SHIFT;

  // Final-beat byte mask: a zero remainder means the last word is full.
  assign tail_bytes_s = len_q[BEAT_SHIFT-1:0];
  assign keep_tail_s  = (keep_t'(1) << tail_bytes_s) - keep_t'(1);

  // Next state, handshakes and request latching.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    ctl_d        = ctl_q;
    beats_left_d = beats_left_q;
    req_ready_s  = 1'b0;
    dsc_load_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_s = room_s;
        if (req_valid && room_s) begin
          if (req_len != '0) begin
            addr_d       = req_addr;
            len_d        = req_len;
            ctl_d        = 16'h0010;
            beats_left_d = beats_calc_s;
            state_d      = ST_DESC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DESC: begin
        dsc_load_s = dsc_ready;
        if (dsc_ready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_DESC;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          beats_left_d = beats_left_q - beats_t'(1);
          if (last_beat_s) begin
            state_d = (outstanding_d < MAX_OUT) ? ST_IDLE : ST_WAIT;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (room_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In-flight counter: a load and a completion in one cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (dsc_load_s && desc_done) begin
      outstanding_d = outstanding_q;
    end else if (dsc_load_s) begin
      outstanding_d = outstanding_q + cnt_t'(1);
    end else if (desc_done && (outstanding_q != cnt_t'(0))) begin
      outstanding_d = outstanding_q - cnt_t'(1);
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Sticky length error: zero-length drop, plus optional tlast disagreement.
  always_comb begin
    err_len_d = err_len_q;
    if (req_fire_s && (req_len == '0)) begin
      err_len_d = 1'b1;
`ifdef XDMA_C2H_LEN_CHECK_EN
    end else if (xfer_s && (s_tlast != last_beat_s)) begin
      err_len_d = 1'b1;
`endif
    end else begin
      err_len_d = err_len_q;
    end
  end

  // State and datapath registers; reset aborts any transfer in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      ctl_q         <= 16'h0000;
      beats_left_q  <= '0;
      outstanding_q <= 4'd0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      ctl_q         <= ctl_d;
      beats_left_q  <= beats_left_d;
      outstanding_q <= outstanding_d;
      err_len_q     <= err_len_d;
    end
  end

  // req_ready is held low for the whole time reset is asserted.
  assign req_ready    = req_ready_s & ~RST;
  assign dsc_load     = dsc_load_s;
  assign dsc_src_addr = 64'd0;
  assign dsc_dst_addr = addr_q;
  assign dsc_len      = len_q;
  assign dsc_ctl      = ctl_q;

  // Zero-latency pass-through only while streaming the payload.
  assign m_tvalid     = in_data_s & s_tvalid;
  assign s_tready     = in_data_s & m_tready;
  assign m_tdata      = s_tdata;
  assign m_tlast      = last_beat_s;
  assign m_tkeep      = (last_beat_s && (tail_bytes_s != '0)) ? keep_tail_s : '1;

  assign outstanding  = outstanding_q;
  assign busy         = (state_q != ST_IDLE) | (outstanding_q != cnt_t'(0));
  assign err_len      = err_len_q;

endmodule

// File: tb/tb_xdma_c2h_desc_issuer.sv
// Self-checking bench for xdma_c2h_desc_issuer (DATA_WIDTH 256, MAX_OUTSTANDING 4).
// The reference model works per transaction: beat counts and keep masks come
// from the byte length, the in-flight count from the loads and completions
// the bench itself schedules.
module tb_xdma_c2h_desc_issuer;

  localparam int MAX = 4;
  localparam int BPB = 32;

  logic         CLK;
  logic         RST;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_addr;
  logic [27:0]  req_len;
  logic         s_tvalid;
  logic         s_tready;
  logic [255:0] s_tdata;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tlast;
  logic         dsc_ready;
  logic         dsc_load;
  logic [63:0]  dsc_src_addr;
  logic [63:0]  dsc_dst_addr;
  logic [27:0]  dsc_len;
  logic [15:0]  dsc_ctl;
  logic         desc_done;
  logic [3:0]   outstanding;
  logic         busy;
  logic         err_len;

  xdma_c2h_desc_issuer dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast),
    .dsc_ready(dsc_ready), .dsc_load(dsc_load), .dsc_src_addr(dsc_src_addr),
    .dsc_dst_addr(dsc_dst_addr), .dsc_len(dsc_len), .dsc_ctl(dsc_ctl),
    .desc_done(desc_done), .outstanding(outstanding), .busy(busy), .err_len(err_len)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int           exp_out  = 0;
  bit           exp_err  = 1'b0;
  bit           in_wait  = 1'b0;
  bit           in_data  = 1'b0;
  bit           active   = 1'b0;
  bit           exp_ready = 1'b0;
  bit           done_en  = 1'b0;
  logic [255:0] exp_tdata;
  bit           exp_tlast;
  logic [31:0]  exp_keep;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic rand_done();
    desc_done = done_en && (exp_out > 0) && ($urandom_range(0, 3) == 0);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit exp_load);
    @(negedge CLK);
    check("req_ready", req_ready, exp_ready);
    check("dsc_load", dsc_load, exp_load);
    check("outstanding", outstanding, exp_out);
    check("busy", busy, active || in_wait || (exp_out != 0));
    check("err_len", err_len, exp_err);
    if (in_data) begin
      check("m_tvalid", m_tvalid, s_tvalid);
      check("s_tready", s_tready, m_tready);
      if (s_tvalid) begin
        check("m_tdata", m_tdata, exp_tdata);
        check("m_tlast", m_tlast, exp_tlast);
        check("m_tkeep", m_tkeep, exp_keep);
      end
    end else begin
      check("m_tvalid_idle", m_tvalid, 1'b0);
      check("s_tready_idle", s_tready, 1'b0);
      check("m_tlast_idle", m_tlast, 1'b0);
    end
    @(posedge CLK);
    if (in_wait && exp_out < MAX) in_wait = 1'b0;
    if (exp_load && desc_done) exp_out = exp_out;
    else if (exp_load) exp_out = exp_out + 1;
    else if (desc_done && exp_out > 0) exp_out = exp_out - 1;
    #1;
  endtask

  task automatic accept(input logic [63:0] a, input logic [27:0] l, output bit ok);
    int guard = 0;
    bit acc = 1'b0;
    req_valid = 1'b1; req_addr = a; req_len = l;
    active = 1'b0; in_data = 1'b0;
    while (!acc && guard < 300) begin
      rand_done();
      dsc_ready = 1'($urandom_range(0, 1));
      s_tvalid  = 1'($urandom_range(0, 1));
      m_tready  = 1'($urandom_range(0, 1));
      exp_ready = !in_wait && (exp_out < MAX);
      acc = exp_ready;
      cycle(1'b0);
      guard++;
    end
    req_valid = 1'b0;
    req_addr = {$urandom(), $urandom()};
    req_len  = 28'($urandom());
    desc_done = 1'b0;
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    else if (l == 28'd0) exp_err = 1'b1;
    ok = acc;
  endtask

  task automatic desc_phase(input logic [63:0] a, input logic [27:0] l);
    int guard = 0;
    bit ld = 1'b0;
    active = 1'b1; exp_ready = 1'b0;
    while (!ld && guard < 200) begin
      rand_done();
      dsc_ready = ($urandom_range(0, 2) != 0);
      s_tvalid  = 1'($urandom_range(0, 1));
      m_tready  = 1'($urandom_range(0, 1));
      ld = dsc_ready;
      cycle(ld);
      guard++;
    end
    dsc_ready = 1'b0;
    desc_done = 1'b0;
    if (!ld) check("desc_timeout", 1'b0, 1'b1);
    check("dsc_dst_addr", dsc_dst_addr, a);
    check("dsc_len", dsc_len, l);
    check("dsc_ctl", dsc_ctl, 16'h0010);
    check("dsc_src_addr", dsc_src_addr, 64'd0);
  endtask

  // mode 0: full rate, 1: m_tready toggles every cycle, 2: random both sides
  task automatic data_phase(input logic [27:0] l, input bit bad, input int mode);
    int n = (int'(l) + BPB - 1) / BPB;
    int r = int'(l) % BPB;
    int idx = 0;
    int guard = 0;
    bit tog = 1'b0;
    bit xf;
    logic [255:0] pl[$];
    for (int i = 0; i < n; i++) pl.push_back({8{$urandom()}});
    in_data = 1'b1; active = 1'b1; exp_ready = 1'b0;
    while (idx < n && guard < 2000) begin
      rand_done();
      dsc_ready = 1'($urandom_range(0, 1));
      case (mode)
        0: begin s_tvalid = 1'b1; m_tready = 1'b1; end
        1: begin s_tvalid = 1'b1; m_tready = tog; tog = ~tog; end
        default: begin s_tvalid = 1'($urandom_range(0, 1)); m_tready = 1'($urandom_range(0, 1)); end
      endcase
      s_tdata   = s_tvalid ? pl[idx] : {8{$urandom()}};
      s_tlast   = bad ? (idx == 0) : (idx == n - 1);
      exp_tdata = pl[idx];
      exp_tlast = (idx == n - 1);
      exp_keep  = (exp_tlast && r != 0) ? ((32'd1 << r) - 32'd1) : 32'hFFFF_FFFF;
      xf = s_tvalid && m_tready;
      cycle(1'b0);
      if (xf) begin
`ifdef XDMA_C2H_LEN_CHECK_EN
        if (s_tlast != exp_tlast) exp_err = 1'b1;
`endif
        idx++;
        if (idx == n) begin
          in_data = 1'b0; active = 1'b0;
          in_wait = (exp_out >= MAX);
        end
      end
      guard++;
    end
    desc_done = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    if (idx != n) check("data_timeout", 1'b0, 1'b1);
  endtask

  task automatic xfer(input logic [63:0] a, input logic [27:0] l, input bit bad, input int mode);
    bit ok;
    accept(a, l, ok);
    if (ok && l != 28'd0) begin
      desc_phase(a, l);
      data_phase(l, bad, mode);
    end
  endtask

  task automatic done_pulse();
    desc_done = 1'b1; exp_ready = !in_wait && (exp_out < MAX);
    cycle(1'b0);
    desc_done = 1'b0;
  endtask

  initial begin
    bit ok;
    RST = 1'b1; req_valid = 1'b0; req_addr = 64'd0; req_len = 28'd0;
    s_tvalid = 1'b0; s_tdata = 256'd0; s_tlast = 1'b0; m_tready = 1'b0;
    dsc_ready = 1'b0; desc_done = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_dsc_load", dsc_load, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_outstanding", outstanding, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_dsc_dst", dsc_dst_addr, 64'd0);
    check("rst_dsc_len", dsc_len, 28'd0);
    check("rst_dsc_ctl", dsc_ctl, 16'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // single aligned request, then unaligned 33-byte request
    done_en = 1'b0;
    xfer(64'h1000, 28'd64, 1'b0, 0);
    done_pulse();
    xfer(64'h2000, 28'd33, 1'b0, 0);
    done_pulse();

    // in-flight limit: four 32-byte packets fill the window, the fifth stalls
    for (int i = 0; i < 4; i++) xfer(64'h4000 + 64'(i * 32), 28'd32, 1'b0, 0);
    req_valid = 1'b1; req_addr = 64'h4080; req_len = 28'd32;
    for (int i = 0; i < 5; i++) begin
      exp_ready = !in_wait && (exp_out < MAX);
      cycle(1'b0);
    end
    done_pulse();
    xfer(64'h4080, 28'd32, 1'b0, 0);

    // upstream tlast on beat 1 of a 64-byte packet
    done_en = 1'b1;
    xfer(64'h5000, 28'd64, 1'b1, 0);
    // backpressure toggling every cycle
    xfer(64'h6000, 28'd256, 1'b0, 1);

    // randomized traffic with random completions
    for (int i = 0; i < 30; i++) begin
      int len = (i % 5 == 0) ? 32 * $urandom_range(1, 6) : $urandom_range(1, 300);
      xfer({$urandom(), $urandom()}, 28'(len), 1'b0, $urandom_range(0, 2));
    end

    // zero-length request is dropped
    xfer(64'h7000, 28'd0, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      exp_ready = !in_wait && (exp_out < MAX);
      cycle(1'b0);
    end

    // reset while beat 1 of 4 is on the bus
    done_en = 1'b0;
    accept(64'h8000, 28'd128, ok);
    desc_phase(64'h8000, 28'd128);
    in_data = 1'b1; active = 1'b1; exp_ready = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b0; s_tlast = 1'b0;
    s_tdata = {8{$urandom()}};
    exp_tdata = s_tdata; exp_tlast = 1'b0; exp_keep = 32'hFFFF_FFFF;
    cycle(1'b0);
    m_tready = 1'b1;
    #2; RST = 1'b1; #1;
    check("arst_m_tvalid", m_tvalid, 1'b0);
    check("arst_m_tlast", m_tlast, 1'b0);
    check("arst_s_tready", s_tready, 1'b0);
    check("arst_outstanding", outstanding, 4'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_req_ready", req_ready, 1'b0);
    check("arst_err_len", err_len, 1'b0);
    check("arst_dsc_len", dsc_len, 28'd0);
    s_tvalid = 1'b0; m_tready = 1'b0;
    exp_out = 0; exp_err = 1'b0; in_wait = 1'b0; in_data = 1'b0; active = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    xfer(64'h9000, 28'd96, 1'b0, 2);
    done_pulse();
    exp_ready = 1'b1;
    cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
